lif_array_controller: RTL
=========================

Name: lif_array_controller

Overview:
- Parametrised successor of the single-neuron LIF control FSM.
- Time-multiplexes one shared LIF datapath over N_CH neurons per frame, one neuron after another.
- Leak shift count is set by parameter. Adds per-neuron refractory tracking, a spike vector and a frame-level done handshake.
- Sits between the host start/valid interface and the shared datapath plus its per-channel state register file.

Parameters:
- N_CH, 4, number of neurons per frame (>=1)
- CH_W, 2, width of channel index (>= clog2(N_CH), >=1)
- LEAK_SHIFTS, 2, number of CAL2 leak-shift cycles (>=1)
- REF_CYCLES, 3, frames a neuron is held refractory after a spike (>=1)
- REF_W, 2, refractory counter width (must hold REF_CYCLES)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  level request; frame begins on high, proceeds after it drops
- i_co  in  1  datapath input-counter carry-out
- spike_out  in  1  datapath threshold-compare result
- ch_idx  out  CH_W  current neuron index, addresses the datapath state file
- s_load, v_load, x_load, v_rest_init, v_th_init, s_init, v_init, x_init, i_init, s_shift, i_en, v_sel, b_sel, spike_load, spike_init  out  1 each  datapath controls, same meaning as previous generation
- a_sel  out  2  ALU A mux
- alu_sel  out  2  ALU op
- ch_valid  out  1  one-cycle pulse: current channel result ready
- spike_vec  out  N_CH  registered spike result of the last frame, bit i = neuron i
- frame_done  out  1  one-cycle pulse: all channels processed, spike_vec valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst low, async): state IDLE, ch_idx 0, leak counter 0, spike_vec 0, all refractory counters 0.
- Outputs in IDLE: all controls 0 except v_sel=1.
- Control outputs are combinational from state. ch_idx, spike_vec and counters are registered.
- States and transitions:
  - IDLE -> INIT when start=1.
  - INIT: s_init, x_init, i_init, spike_init; ch_idx<=0; spike_vec<=0. Stays until start=0, then -> LOAD.
  - LOAD: s_load. If refractory count[ch_idx]!=0 -> SKIP, else -> CAL1.
  - CAL1: a_sel=0, b_sel=0, alu_sel=1, x_load -> LEAK.
  - LEAK: a_sel=1, alu_sel=3, x_load; leak_cnt increments. Exits to CAL3 when leak_cnt==LEAK_SHIFTS-1 (exactly LEAK_SHIFTS cycles); leak_cnt<=0 on exit.
  - CAL3: a_sel=1, b_sel=0, alu_sel=0, x_load -> CAL4.
  - CAL4: i_en, a_sel=1, b_sel=1, alu_sel=0, x_load, s_shift. Held until i_co=1, then -> GET_V.
  - GET_V: v_sel=0, v_load -> GET_S.
  - GET_S: a_sel=2, b_sel=0, alu_sel=2, spike_load. -> HAVE_S if spike_out, else NO_S.
  - HAVE_S: v_sel=1, v_load, ch_valid; spike_vec[ch_idx]<=1; refractory count[ch_idx]<=REF_CYCLES -> NEXT.
  - NO_S: ch_valid -> NEXT.
  - SKIP: ch_valid; refractory count[ch_idx] decrements; spike_vec[ch_idx] stays 0; no datapath writes -> NEXT.
  - NEXT: if ch_idx==N_CH-1 -> DONE, else ch_idx<=ch_idx+1 -> LOAD.
  - DONE: frame_done; ch_idx<=0 -> IDLE.
- Latency per non-refractory channel: 8+LEAK_SHIFTS cycles plus extra CAL4 wait cycles.
- Latency per refractory channel: 3 cycles (LOAD, SKIP, NEXT).
- start is ignored while busy. It is sampled only in IDLE and INIT.
- Refractory counters persist across frames. They are cleared only by reset.
- Reset asserted mid-frame: immediate return to IDLE. spike_vec and counters cleared. No frame_done.
- N_CH=1: NEXT goes directly to DONE. ch_idx stays 0.

Optional Feature:
- Macro LIF_REFRACTORY_EN.
- Defined: refractory counters and SKIP state present as described above.
- Undefined: no counter storage. LOAD always -> CAL1. SKIP is unreachable and absent. REF_CYCLES and REF_W are unused.

Test Plan:
- Reset with rst=0 mid-CAL4, then release -> state IDLE, busy=0, spike_vec=0, v_sel=1, all other controls 0.
- N_CH=4, LEAK_SHIFTS=2, i_co high on the first CAL4 cycle, spike_out=0 for all channels -> four ch_valid pulses 10 cycles apart; frame_done 1 cycle after the last NEXT; spike_vec=0000.
- Same setup, spike_out=1 only for ch 2 -> spike_vec=0100; during HAVE_S v_load=1, v_sel=1 with ch_idx=2.
- LEAK_SHIFTS=3 -> exactly 3 consecutive cycles with alu_sel=3 per channel.
- i_co held low 5 extra cycles on ch 1 -> CAL4 lasts 6 cycles; s_shift and i_en high throughout; no other channel is affected.
- With LIF_REFRACTORY_EN and REF_CYCLES=3, ch 0 spikes in frame 1 -> ch 0 SKIPs in frames 2-4 (spike_vec[0]=0, no v_load) and is processed normally in frame 5. Without the macro, ch 0 is processed in every frame.

Source files
------------

// File: rtl/lif_array_controller_if.sv
// Signal bundle between the LIF array controller, the host start request and the
// shared LIF datapath with its per-channel state file.
interface lif_array_controller_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
);
  logic            start;
  logic            i_co;
  logic            spike_out;
  logic [CH_W-1:0] ch_idx;
  logic            s_load;
  logic            v_load;
  logic            x_load;
  logic            v_rest_init;
  logic            v_th_init;
  logic            s_init;
  logic            v_init;
  logic            x_init;
  logic            i_init;
  logic            s_shift;
  logic            i_en;
  logic            v_sel;
  logic            b_sel;
  logic            spike_load;
  logic            spike_init;
  logic [1:0]      a_sel;
  logic [1:0]      alu_sel;
  logic            ch_valid;
  logic [N_CH-1:0] spike_vec;
  logic            frame_done;
  logic            busy;

  modport master (
    input  start, i_co, spike_out,
    output ch_idx, s_load, v_load, x_load, v_rest_init, v_th_init, s_init, v_init,
           x_init, i_init, s_shift, i_en, v_sel, b_sel, spike_load, spike_init,
           a_sel, alu_sel, ch_valid, spike_vec, frame_done, busy
  );

  modport slave (
    output start, i_co, spike_out,
    input  ch_idx, s_load, v_load, x_load, v_rest_init, v_th_init, s_init, v_init,
           x_init, i_init, s_shift, i_en, v_sel, b_sel, spike_load, spike_init,
           a_sel, alu_sel, ch_valid, spike_vec, frame_done, busy
  );
endinterface

// File: rtl/lif_array_controller.sv
// Frame controller sharing one LIF datapath across N_CH neurons in sequence.
// Define LIF_REFRACTORY_EN to add per-neuron refractory counters and the SKIP state.
module lif_array_controller #(
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int LEAK_SHIFTS = 2,
  parameter int REF_CYCLES  = 3,
  parameter int REF_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  lif_array_controller_if.master bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_LOAD   = 4'd2;
  localparam logic [3:0] S_CAL1   = 4'd3;
  localparam logic [3:0] S_LEAK   = 4'd4;
  localparam logic [3:0] S_CAL3   = 4'd5;
  localparam logic [3:0] S_CAL4   = 4'd6;
  localparam logic [3:0] S_GET_V  = 4'd7;
  localparam logic [3:0] S_GET_S  = 4'd8;
  localparam logic [3:0] S_HAVE_S = 4'd9;
  localparam logic [3:0] S_NO_S   = 4'd10;
  localparam logic [3:0] S_NEXT   = 4'd11;
  localparam logic [3:0] S_DONE   = 4'd12;
`ifdef LIF_REFRACTORY_EN
  localparam logic [3:0] S_SKIP   = 4'd13;
`endif

  localparam int LK_W = (LEAK_SHIFTS > 1) ? $clog2(LEAK_SHIFTS) : 1;

  logic [3:0]      state_q, state_d;
  logic [CH_W-1:0] ch_idx_q, ch_idx_d;
  logic [LK_W-1:0] leak_cnt_q, leak_cnt_d;
  logic [N_CH-1:0] spike_vec_q;
  logic [N_CH-1:0] ch_sel;

  // One-hot decode of the active channel, shared by the spike vector and counters.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch_sel
      assign ch_sel[gi] = (ch_idx_q == CH_W'(gi));
    end
  endgenerate

`ifdef LIF_REFRACTORY_EN
  logic [REF_W-1:0] ref_cnt_q [N_CH];
  logic [N_CH-1:0]  ref_nz;
  logic             ref_hit;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ref_nz
      assign ref_nz[gi] = (ref_cnt_q[gi] != '0);
    end
  endgenerate

  assign ref_hit = |(ref_nz & ch_sel);

  // Counters survive across frames; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) ref_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_sel[i] && state_q == S_HAVE_S) begin
          ref_cnt_q[i] <= REF_W'(REF_CYCLES);
        end else if (ch_sel[i] && state_q == S_SKIP) begin
          ref_cnt_q[i] <= ref_cnt_q[i] - REF_W'(1);
        end
      end
    end
  end
`else
  logic [REF_W-1:0] ref_cfg_unused;
  assign ref_cfg_unused = REF_W'(REF_CYCLES);
`endif

  always_comb begin
    state_d    = state_q;
    ch_idx_d   = ch_idx_q;
    leak_cnt_d = leak_cnt_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_INIT;
      S_INIT: begin
        ch_idx_d = '0;
        if (!bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
`ifdef LIF_REFRACTORY_EN
        state_d = ref_hit ? S_SKIP : S_CAL1;
`else
        state_d = S_CAL1;
`endif
      end
      S_CAL1:   state_d = S_LEAK;
      S_LEAK: begin
        if (leak_cnt_q == LK_W'(LEAK_SHIFTS - 1)) begin
          leak_cnt_d = '0;
          state_d    = S_CAL3;
        end else begin
          leak_cnt_d = leak_cnt_q + LK_W'(1);
        end
      end
      S_CAL3:   state_d = S_CAL4;
      S_CAL4:   if (bus.i_co) state_d = S_GET_V;
      S_GET_V:  state_d = S_GET_S;
      S_GET_S:  state_d = bus.spike_out ? S_HAVE_S : S_NO_S;
      S_HAVE_S: state_d = S_NEXT;
      S_NO_S:   state_d = S_NEXT;
`ifdef LIF_REFRACTORY_EN
      S_SKIP:   state_d = S_NEXT;
`endif
      S_NEXT: begin
        if (ch_idx_q == CH_W'(N_CH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_idx_d = ch_idx_q + CH_W'(1);
          state_d  = S_LOAD;
        end
      end
      S_DONE: begin
        ch_idx_d = '0;
        state_d  = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ch_idx_q   <= '0;
      leak_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_idx_q   <= ch_idx_d;
      leak_cnt_q <= leak_cnt_d;
    end
  end

  // A skipped (refractory) channel never sets its bit, so it reads 0 for that frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spike_vec_q <= '0;
    end else if (state_q == S_INIT) begin
      spike_vec_q <= '0;
    end else if (state_q == S_HAVE_S) begin
      spike_vec_q <= spike_vec_q | ch_sel;
    end
  end

  always_comb begin
    bus.s_load      = 1'b0;
    bus.v_load      = 1'b0;
    bus.x_load      = 1'b0;
    bus.v_rest_init = 1'b0;
    bus.v_th_init   = 1'b0;
    bus.s_init      = 1'b0;
    bus.v_init      = 1'b0;
    bus.x_init      = 1'b0;
    bus.i_init      = 1'b0;
    bus.s_shift     = 1'b0;
    bus.i_en        = 1'b0;
    bus.v_sel       = 1'b0;
    bus.b_sel       = 1'b0;
    bus.spike_load  = 1'b0;
    bus.spike_init  = 1'b0;
    bus.a_sel       = 2'd0;
    bus.alu_sel     = 2'd0;
    bus.ch_valid    = 1'b0;
    bus.frame_done  = 1'b0;
    case (state_q)
      S_IDLE:   bus.v_sel = 1'b1;
      S_INIT: begin
        bus.s_init     = 1'b1;
        bus.x_init     = 1'b1;
        bus.i_init     = 1'b1;
        bus.spike_init = 1'b1;
      end
      S_LOAD:   bus.s_load = 1'b1;
      S_CAL1: begin
        bus.alu_sel = 2'd1;
        bus.x_load  = 1'b1;
      end
      S_LEAK: begin
        bus.a_sel   = 2'd1;
        bus.alu_sel = 2'd3;
        bus.x_load  = 1'b1;
      end
      S_CAL3: begin
        bus.a_sel  = 2'd1;
        bus.x_load = 1'b1;
      end
      S_CAL4: begin
        bus.i_en    = 1'b1;
        bus.a_sel   = 2'd1;
        bus.b_sel   = 1'b1;
        bus.x_load  = 1'b1;
        bus.s_shift = 1'b1;
      end
      S_GET_V:  bus.v_load = 1'b1;
      S_GET_S: begin
        bus.a_sel      = 2'd2;
        bus.alu_sel    = 2'd2;
        bus.spike_load = 1'b1;
      end
      S_HAVE_S: begin
        bus.v_sel    = 1'b1;
        bus.v_load   = 1'b1;
        bus.ch_valid = 1'b1;
      end
      S_NO_S:   bus.ch_valid = 1'b1;
`ifdef LIF_REFRACTORY_EN
      S_SKIP:   bus.ch_valid = 1'b1;
`endif
      S_DONE:   bus.frame_done = 1'b1;
      default:  ;
    endcase
  end

  assign bus.ch_idx    = ch_idx_q;
  assign bus.spike_vec = spike_vec_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
